// File: rtl/rot_apply_engine_pkg.sv
// Shared types and shift helper for the folded CORDIC rotation engine.
package rot_apply_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int SHIFT_W = 16;
  localparam int ASR_W   = 64;

  // Arithmetic right shift of a sign-extended operand; shifting by the
  // datapath width or more collapses to pure sign bits (0 or -1).
  function automatic logic signed [ASR_W-1:0] asr_sat(
    input logic signed [ASR_W-1:0] v,
    input logic [SHIFT_W-1:0]      s,
    input int unsigned             w
  );
    if (32'(s) >= w) return v[ASR_W-1] ? '1 : '0;
    return v >>> s;
  endfunction

endpackage

// File: rtl/rot_apply_engine_if.sv
// Job/result handshake bundle between a source and the rotation engine.
interface rot_apply_engine_if #(
  parameter int CORDIC_WIDTH = 22,
  parameter int N_STAGES     = 16
);
  logic                           in_valid;
  logic                           in_ready;
  logic signed [CORDIC_WIDTH-1:0] x_in;
  logic signed [CORDIC_WIDTH-1:0] y_in;
  logic [N_STAGES-1:0]            micro_rot_in;
  logic                           inverse_in;
  logic                           out_valid;
  logic                           out_ready;
  logic signed [CORDIC_WIDTH-1:0] x_out;
  logic signed [CORDIC_WIDTH-1:0] y_out;

  modport master (
    output in_valid, x_in, y_in, micro_rot_in, inverse_in, out_ready,
    input  in_ready, out_valid, x_out, y_out
  );

  modport slave (
    input  in_valid, x_in, y_in, micro_rot_in, inverse_in, out_ready,
    output in_ready, out_valid, x_out, y_out
  );
endinterface

// File: rtl/rot_apply_engine_micro_step.sv
// One CORDIC micro-rotation: simultaneous x/y update by a shifted cross term.
module rot_micro_step
  import rot_apply_pkg::*;
#(
  parameter int W       = 22,
  parameter int SHIFT_W = rot_apply_pkg::SHIFT_W
) (
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  input  logic [SHIFT_W-1:0]  s,
  input  logic                d,
  output logic signed [W-1:0] x_nxt,
  output logic signed [W-1:0] y_nxt
);
  logic signed [ASR_W-1:0] x_ext, y_ext;
  logic signed [W-1:0]     x_sh, y_sh;

  assign x_ext = ASR_W'(x);
  assign y_ext = ASR_W'(y);
  assign x_sh  = W'(asr_sat(x_ext, s, W));
  assign y_sh  = W'(asr_sat(y_ext, s, W));

  // d=1 turns the rotation the other way; sums wrap at W bits by design.
  always_comb begin
    if (d) begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
    end
  end
endmodule

// File: rtl/rot_apply_engine.sv
// Folded CORDIC rotation-mode engine: replays vectoring direction bits one
// micro-rotation per clock; output keeps the uncompensated CORDIC gain.
module rot_apply_engine
  import rot_apply_pkg::*;
#(
  parameter int CORDIC_WIDTH = 22,
  parameter int N_STAGES     = 16,
  parameter int STAGE_START  = 0,
  parameter int CNT_W        = $clog2(N_STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  rot_apply_engine_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_STAGES - 1);

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic signed [CORDIC_WIDTH-1:0] x_q, y_q, x_d, y_d, x_step, y_step;
  logic [N_STAGES-1:0]            rot_q, rot_d;
  logic                           inv_q, inv_d;
  logic [SHIFT_W-1:0]             shift;

  assign shift = SHIFT_W'(STAGE_START) + SHIFT_W'(cnt_q);

  // rot_q is consumed LSB-first, so bit 0 always holds the current stage.
  rot_micro_step #(.W(CORDIC_WIDTH), .SHIFT_W(SHIFT_W)) u_step (
    .x    (x_q),
    .y    (y_q),
    .s    (shift),
    .d    (rot_q[0] ^ inv_q),
    .x_nxt(x_step),
    .y_nxt(y_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rot_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rot_q   <= rot_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    rot_d   = rot_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.x_in;
          y_d     = bus.y_in;
          rot_d   = bus.micro_rot_in;
          inv_d   = bus.inverse_in;
          cnt_d   = '0;
          state_d = ROTATE;
        end
      end
      ROTATE: begin
        x_d   = x_step;
        y_d   = y_step;
        rot_d = rot_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.x_out     = x_q;
  assign bus.y_out     = y_q;

endmodule

// File: tb/tb_rot_apply_engine.sv
// Randomised self-checking bench for rot_apply_engine across several sizings.
module tb_rot_apply_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rot_apply_engine_if #(.CORDIC_WIDTH(22), .N_STAGES(1))  ifa ();
  rot_apply_engine_if #(.CORDIC_WIDTH(22), .N_STAGES(2))  ifb ();
  rot_apply_engine_if #(.CORDIC_WIDTH(8),  .N_STAGES(1))  ifc ();
  rot_apply_engine_if #(.CORDIC_WIDTH(22), .N_STAGES(16)) ifd ();

  rot_apply_engine #(.CORDIC_WIDTH(22), .N_STAGES(1),  .STAGE_START(0)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  rot_apply_engine #(.CORDIC_WIDTH(22), .N_STAGES(2),  .STAGE_START(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  rot_apply_engine #(.CORDIC_WIDTH(8),  .N_STAGES(1),  .STAGE_START(0)) dut_c (.clk(clk), .reset(reset), .bus(ifc));
  rot_apply_engine #(.CORDIC_WIDTH(22), .N_STAGES(16), .STAGE_START(0)) dut_d (.clk(clk), .reset(reset), .bus(ifd));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference arithmetic: floor division by 2^s and two's-complement wrap.
  function automatic longint fdiv(input longint v, input int s);
    longint p;
    p = longint'(1) << s;
    if (v >= 0) return v / p;
    return -((-v + p - 1) / p);
  endfunction

  function automatic longint wrapw(input longint v, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  task automatic model_rot(input longint xi, input longint yi, input logic [63:0] dirs,
                           input bit inv, input int n, input int start, input int w,
                           output longint xo, output longint yo);
    longint x, y, xs, ys, nx, ny;
    x = wrapw(xi, w);
    y = wrapw(yi, w);
    for (int k = 0; k < n; k++) begin
      xs = fdiv(x, start + k);
      ys = fdiv(y, start + k);
      if (dirs[k] ^ inv) begin nx = x - ys; ny = y + xs; end
      else               begin nx = x + ys; ny = y - xs; end
      x = wrapw(nx, w);
      y = wrapw(ny, w);
    end
    xo = x;
    yo = y;
  endtask

  // Run one job on the 16-stage engine; lat counts edges from the accept edge.
  task automatic job_d(input longint x, input longint y, input logic [15:0] dirs, input bit inv,
                       output longint gx, output longint gy, output int lat);
    ifd.x_in = 22'(x);
    ifd.y_in = 22'(y);
    ifd.micro_rot_in = dirs;
    ifd.inverse_in = inv;
    ifd.in_valid = 1'b1;
    tick;
    lat = 1;
    ifd.in_valid = 1'b0;
    ifd.x_in = 22'($urandom);
    ifd.y_in = 22'($urandom);
    ifd.micro_rot_in = 16'($urandom);
    while (ifd.out_valid !== 1'b1 && lat < 200) begin
      tick;
      lat++;
    end
    gx = ifd.x_out;
    gy = ifd.y_out;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ifd.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", ifd.in_ready); end
    checks++; if (ifd.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ifd.out_valid); end
    checks++; if (ifd.x_out !== 22'sd0 || ifd.y_out !== 22'sd0) begin failures++; $display("FAIL reset_xy got=%0d,%0d exp=0,0", ifd.x_out, ifd.y_out); end
    checks++; if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0) begin failures++; $display("FAIL reset_a got=%b%b exp=10", ifa.in_ready, ifa.out_valid); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_n1(input bit inv);
    longint exp_y;
    exp_y = inv ? 100 : -100;
    ifa.x_in = 22'sd100;
    ifa.y_in = 22'sd0;
    ifa.micro_rot_in = 1'b0;
    ifa.inverse_in = inv;
    ifa.in_valid = 1'b1;
    tick;
    ifa.in_valid = 1'b0;
    checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL n1_early_valid got=%b exp=0", ifa.out_valid); end
    tick;
    checks++; if (ifa.out_valid !== 1'b1) begin failures++; $display("FAIL n1_latency got=%b exp=1", ifa.out_valid); end
    checks++; if (ifa.x_out !== 22'sd100) begin failures++; $display("FAIL n1_x got=%0d exp=100", ifa.x_out); end
    checks++; if (longint'(ifa.y_out) != exp_y) begin failures++; $display("FAIL n1_y got=%0d exp=%0d", ifa.y_out, exp_y); end
    tick;
    checks++; if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1) begin failures++; $display("FAIL n1_release got=%b%b exp=01", ifa.out_valid, ifa.in_ready); end
  endtask

  task automatic test_n2;
    ifb.x_in = 22'sd64;
    ifb.y_in = 22'sd0;
    ifb.micro_rot_in = 2'b00;
    ifb.inverse_in = 1'b0;
    ifb.in_valid = 1'b1;
    tick;
    ifb.in_valid = 1'b0;
    tick;
    checks++; if (ifb.out_valid !== 1'b0) begin failures++; $display("FAIL n2_early_valid got=%b exp=0", ifb.out_valid); end
    checks++; if (ifb.x_out !== 22'sd64 || ifb.y_out !== -22'sd64) begin failures++; $display("FAIL n2_stage0 got=%0d,%0d exp=64,-64", ifb.x_out, ifb.y_out); end
    tick;
    checks++; if (ifb.out_valid !== 1'b1) begin failures++; $display("FAIL n2_latency got=%b exp=1", ifb.out_valid); end
    checks++; if (ifb.x_out !== 22'sd32 || ifb.y_out !== -22'sd96) begin failures++; $display("FAIL n2_final got=%0d,%0d exp=32,-96", ifb.x_out, ifb.y_out); end
    tick;
  endtask

  task automatic test_wrap;
    ifc.x_in = 8'sd127;
    ifc.y_in = 8'sd127;
    ifc.micro_rot_in = 1'b1;
    ifc.inverse_in = 1'b0;
    ifc.in_valid = 1'b1;
    tick;
    ifc.in_valid = 1'b0;
    tick;
    checks++; if (ifc.out_valid !== 1'b1) begin failures++; $display("FAIL wrap_valid got=%b exp=1", ifc.out_valid); end
    checks++; if (ifc.x_out !== 8'sd0 || ifc.y_out !== -8'sd2) begin failures++; $display("FAIL wrap_xy got=%0d,%0d exp=0,-2", ifc.x_out, ifc.y_out); end
    tick;
  endtask

  task automatic test_random;
    logic signed [21:0] rx, ry;
    logic [15:0] rd;
    bit ri;
    longint ex, ey, gx, gy;
    int lat;
    for (int i = 0; i < 20; i++) begin
      rx = 22'($urandom);
      ry = 22'($urandom);
      if (i < 10) begin rx = rx >>> 2; ry = ry >>> 2; end
      rd = 16'($urandom);
      ri = 1'($urandom);
      model_rot(rx, ry, 64'(rd), ri, 16, 0, 22, ex, ey);
      job_d(rx, ry, rd, ri, gx, gy, lat);
      checks++; if (lat != 17) begin failures++; $display("FAIL rand_latency[%0d] got=%0d exp=17", i, lat); end
      checks++; if (gx != ex || gy != ey) begin failures++; $display("FAIL rand_xy[%0d] got=%0d,%0d exp=%0d,%0d", i, gx, gy, ex, ey); end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    longint ex, ey, gx, gy, hx, hy;
    int lat;
    ifd.out_ready = 1'b0;
    model_rot(12345, -6789, 64'(16'hA5C3), 1'b0, 16, 0, 22, ex, ey);
    job_d(12345, -6789, 16'hA5C3, 1'b0, gx, gy, lat);
    checks++; if (gx != ex || gy != ey || lat != 17) begin failures++; $display("FAIL bp_first got=%0d,%0d lat=%0d exp=%0d,%0d lat=17", gx, gy, lat, ex, ey); end
    hx = gx;
    hy = gy;
    ifd.x_in = -22'sd40000;
    ifd.y_in = 22'sd77777;
    ifd.micro_rot_in = 16'h0F0F;
    ifd.inverse_in = 1'b1;
    ifd.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick;
      checks++; if (ifd.out_valid !== 1'b1 || ifd.in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_ctl[%0d] got=%b%b exp=10", c, ifd.out_valid, ifd.in_ready); end
      checks++; if (longint'(ifd.x_out) != hx || longint'(ifd.y_out) != hy) begin failures++; $display("FAIL bp_hold_xy[%0d] got=%0d,%0d exp=%0d,%0d", c, ifd.x_out, ifd.y_out, hx, hy); end
    end
    ifd.out_ready = 1'b1;
    tick;
    checks++; if (ifd.out_valid !== 1'b0 || ifd.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b%b exp=01", ifd.out_valid, ifd.in_ready); end
    model_rot(-40000, 77777, 64'(16'h0F0F), 1'b1, 16, 0, 22, ex, ey);
    tick;
    ifd.in_valid = 1'b0;
    lat = 1;
    while (ifd.out_valid !== 1'b1 && lat < 200) begin tick; lat++; end
    checks++; if (lat != 17) begin failures++; $display("FAIL bp_second_latency got=%0d exp=17", lat); end
    checks++; if (longint'(ifd.x_out) != ex || longint'(ifd.y_out) != ey) begin failures++; $display("FAIL bp_second_xy got=%0d,%0d exp=%0d,%0d", ifd.x_out, ifd.y_out, ex, ey); end
    tick;
  endtask

  task automatic test_round_trip;
    logic [15:0] dv;
    longint x, y, xs, ys, nx, ny, ex, ey, gx, gy, rx, ry;
    real k2, tx, ty;
    int lat;
    x = 1000;
    y = 500;
    k2 = 1.0;
    for (int k = 0; k < 16; k++) begin
      dv[k] = (y < 0);
      xs = fdiv(x, k);
      ys = fdiv(y, k);
      if (dv[k]) begin nx = x - ys; ny = y + xs; end
      else       begin nx = x + ys; ny = y - xs; end
      x = nx;
      y = ny;
      k2 = k2 * (1.0 + 1.0 / real'(longint'(1) << (2 * k)));
    end
    model_rot(1000, 500, 64'(dv), 1'b0, 16, 0, 22, ex, ey);
    job_d(1000, 500, dv, 1'b0, gx, gy, lat);
    checks++; if (gx != ex || gy != ey) begin failures++; $display("FAIL rt_forward got=%0d,%0d exp=%0d,%0d", gx, gy, ex, ey); end
    tick;
    model_rot(gx, gy, 64'(dv), 1'b1, 16, 0, 22, ex, ey);
    job_d(gx, gy, dv, 1'b1, rx, ry, lat);
    checks++; if (rx != ex || ry != ey) begin failures++; $display("FAIL rt_inverse got=%0d,%0d exp=%0d,%0d", rx, ry, ex, ey); end
    tx = k2 * 1000.0;
    ty = k2 * 500.0;
    checks++;
    if ((real'(rx) - tx) > 16.0 || (tx - real'(rx)) > 16.0 || (real'(ry) - ty) > 16.0 || (ty - real'(ry)) > 16.0) begin
      failures++;
      $display("FAIL rt_gain got=%0d,%0d exp=%0.1f,%0.1f tol=16", rx, ry, tx, ty);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    longint ex, ey, gx, gy;
    int lat;
    ifd.x_in = 22'sd300000;
    ifd.y_in = -22'sd123456;
    ifd.micro_rot_in = 16'h3C5A;
    ifd.inverse_in = 1'b0;
    ifd.in_valid = 1'b1;
    tick;
    ifd.in_valid = 1'b0;
    repeat (5) tick;
    reset = 1'b1;
    #1;
    checks++; if (ifd.out_valid !== 1'b0 || ifd.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ctl got=%b%b exp=01", ifd.out_valid, ifd.in_ready); end
    checks++; if (ifd.x_out !== 22'sd0 || ifd.y_out !== 22'sd0) begin failures++; $display("FAIL rstmid_xy got=%0d,%0d exp=0,0", ifd.x_out, ifd.y_out); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick;
    model_rot(-5000, 9000, 64'(16'h8001), 1'b0, 16, 0, 22, ex, ey);
    job_d(-5000, 9000, 16'h8001, 1'b0, gx, gy, lat);
    checks++; if (lat != 17 || gx != ex || gy != ey) begin failures++; $display("FAIL rstmid_next got=%0d,%0d lat=%0d exp=%0d,%0d lat=17", gx, gy, lat, ex, ey); end
    tick;
  endtask

  initial begin
    ifa.in_valid = 1'b0; ifa.x_in = '0; ifa.y_in = '0; ifa.micro_rot_in = '0; ifa.inverse_in = 1'b0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.x_in = '0; ifb.y_in = '0; ifb.micro_rot_in = '0; ifb.inverse_in = 1'b0; ifb.out_ready = 1'b1;
    ifc.in_valid = 1'b0; ifc.x_in = '0; ifc.y_in = '0; ifc.micro_rot_in = '0; ifc.inverse_in = 1'b0; ifc.out_ready = 1'b1;
    ifd.in_valid = 1'b0; ifd.x_in = '0; ifd.y_in = '0; ifd.micro_rot_in = '0; ifd.inverse_in = 1'b0; ifd.out_ready = 1'b1;
    test_reset;
    test_n1(1'b0);
    test_n1(1'b1);
    test_n2;
    test_wrap;
    test_random;
    test_back_to_back;
    test_round_trip;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
